// File: rtl/shift_issue_if.sv
// Handshake and payload bundle between the decode side, the shift issue stage and the shifter.
interface shift_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        is_imm;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  imm_shamt;
   logic [4:0]  rd_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sh_a;
   logic [4:0]  sh_shamt;
   logic [1:0]  sh_type;
   logic [4:0]  rd_out;
   logic        illegal;

   modport master (
      output in_valid, funct3, funct7_5, is_imm, rs1_data, rs2_data, imm_shamt, rd_in,
      output out_ready,
      input  in_ready, out_valid, sh_a, sh_shamt, sh_type, rd_out, illegal
   );

   modport slave (
      input  in_valid, funct3, funct7_5, is_imm, rs1_data, rs2_data, imm_shamt, rd_in,
      input  out_ready,
      output in_ready, out_valid, sh_a, sh_shamt, sh_type, rd_out, illegal
   );
endinterface

// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the EX shifter: decodes shift type/amount and holds
// the result in an output register backed by a one-entry skid buffer.
module shift_issue_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   shift_issue_if.slave bus
);

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [1:0]  typ;
      logic [4:0]  rd;
      logic        illegal;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{a: 32'd0, shamt: 5'd0, typ: 2'b11, rd: 5'd0, illegal: 1'b0};

   entry_t in_entry;
   entry_t or_data_reg, or_data_next;
   entry_t sk_data_reg, sk_data_next;
   logic   or_valid_reg, or_valid_next;
   logic   sk_valid_reg, sk_valid_next;
   logic   accept;
   logic   xfer;
   logic   unused_rs2_hi;

   assign unused_rs2_hi = ^bus.rs2_data[31:5];

   always_comb begin
      in_entry.a       = bus.rs1_data;
      in_entry.shamt   = bus.is_imm ? bus.imm_shamt : bus.rs2_data[4:0];
      in_entry.rd      = bus.rd_in;
      in_entry.typ     = 2'b11;
      in_entry.illegal = 1'b1;
      case ({bus.funct3, bus.funct7_5})
         4'b001_0: begin in_entry.typ = 2'b01; in_entry.illegal = 1'b0; end
         4'b101_0: begin in_entry.typ = 2'b00; in_entry.illegal = 1'b0; end
         4'b101_1: begin in_entry.typ = 2'b10; in_entry.illegal = 1'b0; end
         default:  ;
      endcase
   end

   assign bus.in_ready = !sk_valid_reg;
   assign accept       = bus.in_valid && !sk_valid_reg;
   assign xfer         = or_valid_reg && bus.out_ready;

   always_comb begin
      or_valid_next = or_valid_reg;
      sk_valid_next = sk_valid_reg;
      or_data_next  = or_data_reg;
      sk_data_next  = sk_data_reg;
      if (flush) begin
         or_valid_next = 1'b0;
         sk_valid_next = 1'b0;
      end else if (!or_valid_reg || xfer) begin
         // The skid entry is older than anything upstream, so it always refills OR first.
         if (sk_valid_reg) begin
            or_valid_next = 1'b1;
            or_data_next  = sk_data_reg;
            sk_valid_next = 1'b0;
         end else if (accept) begin
            or_valid_next = 1'b1;
            or_data_next  = in_entry;
         end else begin
            or_valid_next = 1'b0;
         end
      end else if (accept) begin
         sk_valid_next = 1'b1;
         sk_data_next  = in_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_valid_reg <= 1'b0;
         sk_valid_reg <= 1'b0;
         or_data_reg  <= RESET_ENTRY;
         sk_data_reg  <= RESET_ENTRY;
      end else begin
         or_valid_reg <= or_valid_next;
         sk_valid_reg <= sk_valid_next;
         or_data_reg  <= or_data_next;
         sk_data_reg  <= sk_data_next;
      end
   end

   assign bus.out_valid = or_valid_reg;
   assign bus.sh_a      = or_data_reg.a;
   assign bus.sh_shamt  = or_data_reg.shamt;
   assign bus.sh_type   = or_data_reg.typ;
   assign bus.rd_out    = or_data_reg.rd;
   assign bus.illegal   = or_data_reg.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed scenarios plus randomized traffic
// against a two-deep FIFO reference model.
module tb_shift_issue_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   shift_issue_if bus ();

   shift_issue_stage dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {a, shamt, type, rd, illegal}
   typedef logic [44:0] exp_t;
   exp_t model_q[$];

   function automatic exp_t expect_of(input logic [2:0] f3, input logic f7, input logic imm,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic [4:0] ish, input logic [4:0] rd);
      logic [1:0] t;
      logic       ill;
      logic [4:0] amt;
      ill = 1'b0;
      if (f3 == 3'd1 && f7 == 1'b0)      t = 2'b01;
      else if (f3 == 3'd5 && f7 == 1'b0) t = 2'b00;
      else if (f3 == 3'd5 && f7 == 1'b1) t = 2'b10;
      else begin t = 2'b11; ill = 1'b1; end
      amt = imm ? ish : 5'(rs2 % 32);
      return {rs1, amt, t, rd, ill};
   endfunction

   task automatic set_in(input logic v, input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] ish, input logic [4:0] rd);
      bus.in_valid  = v;
      bus.funct3    = f3;
      bus.funct7_5  = f7;
      bus.is_imm    = imm;
      bus.rs1_data  = rs1;
      bus.rs2_data  = rs2;
      bus.imm_shamt = ish;
      bus.rd_in     = rd;
   endtask

   // Advance one clock and update the reference FIFO; returns at the following falling edge.
   task automatic tick();
      bit   acc;
      bit   xf;
      exp_t e;
      acc = bus.in_valid && (model_q.size() < 2);
      xf  = (model_q.size() > 0) && bus.out_ready;
      e   = expect_of(bus.funct3, bus.funct7_5, bus.is_imm, bus.rs1_data, bus.rs2_data,
                      bus.imm_shamt, bus.rd_in);
      @(posedge clk);
      if (flush) model_q.delete();
      else begin
         if (xf) void'(model_q.pop_front());
         if (acc) model_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.sh_a, bus.sh_shamt, bus.sh_type, bus.rd_out, bus.illegal}
          !== {1'b0, 1'b1, 32'd0, 5'd0, 2'b11, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got v=%0b rdy=%0b a=%h amt=%0d t=%b rd=%0d ill=%0b, expected v=0 rdy=1 a=0 amt=0 t=11 rd=0 ill=0",
                  bus.out_valid, bus.in_ready, bus.sh_a, bus.sh_shamt, bus.sh_type, bus.rd_out, bus.illegal);
      end
      rst = 1'b0;
      @(negedge clk);
      $display("reset: out_valid=%0b in_ready=%0b sh_type=%b", bus.out_valid, bus.in_ready, bus.sh_type);
   endtask

   task automatic test_slli();
      bus.out_ready = 1'b1;
      set_in(1'b1, 3'b001, 1'b0, 1'b1, 32'h0000_00F1, 32'h0, 5'd4, 5'd7);
      tick();
      set_in(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
      checks++;
      if ({bus.out_valid, bus.sh_type, bus.sh_shamt, bus.sh_a, bus.illegal, bus.rd_out}
          !== {1'b1, 2'b01, 5'd4, 32'h0000_00F1, 1'b0, 5'd7}) begin
         errors++;
         $display("FAIL slli: got v=%0b t=%b amt=%0d a=%h ill=%0b rd=%0d, expected v=1 t=01 amt=4 a=000000f1 ill=0 rd=7",
                  bus.out_valid, bus.sh_type, bus.sh_shamt, bus.sh_a, bus.illegal, bus.rd_out);
      end
      $display("slli: v=%0b t=%b amt=%0d a=%h", bus.out_valid, bus.sh_type, bus.sh_shamt, bus.sh_a);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL slli_drain: got out_valid=%0b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_sra_reg();
      bus.out_ready = 1'b1;
      set_in(1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_1234, 32'hFFFF_FFE3, 5'd17, 5'd9);
      tick();
      set_in(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
      checks++;
      if ({bus.out_valid, bus.sh_type, bus.sh_shamt, bus.sh_a} !== {1'b1, 2'b10, 5'd3, 32'h8000_1234}) begin
         errors++;
         $display("FAIL sra_reg: got v=%0b t=%b amt=%0d a=%h, expected v=1 t=10 amt=3 a=80001234",
                  bus.out_valid, bus.sh_type, bus.sh_shamt, bus.sh_a);
      end
      $display("sra_reg: t=%b amt=%0d", bus.sh_type, bus.sh_shamt);
      tick();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      set_in(1'b1, 3'b001, 1'b0, 1'b1, 32'hAAAA_0001, 32'h0, 5'd1, 5'd1);
      tick();
      set_in(1'b1, 3'b101, 1'b0, 1'b1, 32'hBBBB_0002, 32'h0, 5'd2, 5'd2);
      tick();
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.sh_a} !== {1'b0, 1'b1, 32'hAAAA_0001}) begin
         errors++;
         $display("FAIL bp_full: got rdy=%0b v=%0b a=%h, expected rdy=0 v=1 a=aaaa0001",
                  bus.in_ready, bus.out_valid, bus.sh_a);
      end
      set_in(1'b1, 3'b101, 1'b1, 1'b1, 32'hCCCC_0003, 32'h0, 5'd3, 5'd3);
      tick();
      checks++;
      if ({bus.in_ready, bus.sh_a, bus.sh_shamt} !== {1'b0, 32'hAAAA_0001, 5'd1}) begin
         errors++;
         $display("FAIL bp_hold: got rdy=%0b a=%h amt=%0d, expected rdy=0 a=aaaa0001 amt=1",
                  bus.in_ready, bus.sh_a, bus.sh_shamt);
      end
      bus.out_ready = 1'b1;
      tick();
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.sh_a, bus.rd_out} !== {1'b1, 1'b1, 32'hBBBB_0002, 5'd2}) begin
         errors++;
         $display("FAIL bp_second: got v=%0b rdy=%0b a=%h rd=%0d, expected v=1 rdy=1 a=bbbb0002 rd=2",
                  bus.out_valid, bus.in_ready, bus.sh_a, bus.rd_out);
      end
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.sh_a, bus.sh_type} !== {1'b1, 32'hCCCC_0003, 2'b10}) begin
         errors++;
         $display("FAIL bp_third: got v=%0b a=%h t=%b, expected v=1 a=cccc0003 t=10",
                  bus.out_valid, bus.sh_a, bus.sh_type);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got out_valid=%0b expected 0", bus.out_valid);
      end
      $display("backpressure: A,B,C delivered in order");
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      set_in(1'b1, 3'b000, 1'b1, 1'b0, 32'h1357_9BDF, 32'h0000_0011, 5'd0, 5'd12);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.sh_type, bus.illegal, bus.sh_a, bus.sh_shamt}
          !== {1'b1, 2'b11, 1'b1, 32'h1357_9BDF, 5'd17}) begin
         errors++;
         $display("FAIL illegal: got v=%0b t=%b ill=%0b a=%h amt=%0d, expected v=1 t=11 ill=1 a=13579bdf amt=17",
                  bus.out_valid, bus.sh_type, bus.illegal, bus.sh_a, bus.sh_shamt);
      end
      $display("illegal: t=%b ill=%0b", bus.sh_type, bus.illegal);
      tick();
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      set_in(1'b1, 3'b001, 1'b0, 1'b1, 32'h1111_1111, 32'h0, 5'd5, 5'd5);
      tick();
      set_in(1'b1, 3'b101, 1'b0, 1'b1, 32'h2222_2222, 32'h0, 5'd6, 5'd6);
      tick();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_prefill: got in_ready=%0b expected 0", bus.in_ready);
      end
      flush = 1'b1;
      set_in(1'b1, 3'b001, 1'b0, 1'b1, 32'h3333_3333, 32'h0, 5'd7, 5'd7);
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL flush_clear: got v=%0b rdy=%0b, expected v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      set_in(1'b1, 3'b101, 1'b1, 1'b1, 32'h4444_4444, 32'h0, 5'd8, 5'd8);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.sh_a} !== {1'b1, 32'h4444_4444}) begin
         errors++;
         $display("FAIL flush_refill: got v=%0b a=%h, expected v=1 a=44444444", bus.out_valid, bus.sh_a);
      end
      $display("flush: cleared and refilled, a=%h", bus.sh_a);
      bus.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_random();
      int   n_out;
      exp_t got;
      n_out = 0;
      for (int i = 0; i < 600; i++) begin
         logic [2:0] f3;
         f3 = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1) != 0) ? 3'd5 : 3'd1)
                                          : 3'($urandom_range(0, 7));
         set_in(1'($urandom_range(0, 3) != 0), f3, 1'($urandom), 1'($urandom), $urandom,
                $urandom, 5'($urandom), 5'($urandom));
         bus.out_ready = 1'($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 24) == 0);
         tick();
         checks++;
         if (bus.out_valid !== (model_q.size() > 0) || bus.in_ready !== (model_q.size() < 2)) begin
            errors++;
            $display("FAIL rand_hs cycle %0d: got v=%0b rdy=%0b, expected v=%0b rdy=%0b", i,
                     bus.out_valid, bus.in_ready, model_q.size() > 0, model_q.size() < 2);
         end
         if (model_q.size() > 0) begin
            got = {bus.sh_a, bus.sh_shamt, bus.sh_type, bus.rd_out, bus.illegal};
            checks++;
            if (got !== model_q[0]) begin
               errors++;
               $display("FAIL rand_payload cycle %0d: got %h expected %h", i, got, model_q[0]);
            end
            if (bus.out_ready) n_out++;
         end
      end
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      $display("random: 600 cycles, about %0d entries observed", n_out);
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      set_in(1'b1, 3'b101, 1'b0, 1'b1, 32'h5555_5555, 32'h0, 5'd9, 5'd9);
      tick();
      set_in(1'b1, 3'b001, 1'b0, 1'b1, 32'h6666_6666, 32'h0, 5'd10, 5'd10);
      tick();
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, bus.sh_type, bus.in_ready} !== {1'b0, 2'b11, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: got v=%0b t=%b rdy=%0b, expected v=0 t=11 rdy=1",
                  bus.out_valid, bus.sh_type, bus.in_ready);
      end
      model_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      set_in(1'b1, 3'b001, 1'b0, 1'b0, 32'h7777_7777, 32'h0000_001F, 5'd0, 5'd11);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.sh_a, bus.sh_shamt} !== {1'b1, 32'h7777_7777, 5'd31}) begin
         errors++;
         $display("FAIL post_reset: got v=%0b a=%h amt=%0d, expected v=1 a=77777777 amt=31",
                  bus.out_valid, bus.sh_a, bus.sh_shamt);
      end
      $display("async_reset: v=%0b t=%b after reset, resumed a=%h", 1'b0, 2'b11, bus.sh_a);
      tick();
   endtask

   initial begin
      set_in(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
      bus.out_ready = 1'b0;
      test_reset();
      test_slli();
      test_sra_reg();
      test_backpressure();
      test_illegal();
      test_flush();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue stage that sits directly upstream of the combinational shifter in the EX path. It accepts decoded shift instructions (SLL/SRL/SRA and their immediate forms), selects the operand and shift amount, and translates funct3/funct7 into the shifter's 2-bit type code. It holds the result in an output register backed by a one-entry skid buffer, so the valid/ready handshake on both sides is fully registered.

## Interface
- No parameters; data width is fixed at 32, shift amount at 5.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; equals !skid_valid.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- is_imm  in  1  1 = SLLI/SRLI/SRAI, 0 = register form.
- rs1_data  in  32  operand to shift.
- rs2_data  in  32  register-form shift source; only bits [4:0] used.
- imm_shamt  in  5  immediate shift amount (instr[24:20]).
- rd_in  in  5  destination register tag.
- out_valid  out  1  shifter inputs valid.
- out_ready  in  1  downstream accepts.
- sh_a  out  32  shifter operand.
- sh_shamt  out  5  shifter amount.
- sh_type  out  2  00 = logical right, 01 = left, 10 = arithmetic right, 11 = pass-through.
- rd_out  out  5  destination tag, travels with data.
- illegal  out  1  entry was not a legal shift encoding.

## Operation
- Decode is combinational on the input side and is captured with the payload:
  - funct3=001, funct7_5=0 -> type 01.
  - funct3=101, funct7_5=0 -> type 00.
  - funct3=101, funct7_5=1 -> type 10.
  - Any other combination -> type 11, illegal=1; the entry still flows, and sh_a = rs1_data.
- shamt = is_imm ? imm_shamt : rs2_data[4:0]; rs2_data[31:5] are ignored.
- Storage is an output register (OR) plus a skid register (SK), each with a valid bit.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Per cycle, with flush=0, the priority is:
  - OR empty, or OR transferring: if SK is valid, OR <= SK and SK is cleared. Otherwise, an accepted input goes to OR.
  - OR full and not transferring: an accepted input goes to SK.
- Since in_ready = !skid_valid, no input is accepted in a cycle where SK drains into OR.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- flush=1: both valid bits clear at the next edge and any input in that cycle is discarded. flush has priority over every other event.

## Timing
- Reset (async assert): OR and SK valid = 0, out_valid = 0, sh_a = 0, sh_shamt = 0, sh_type = 2'b11, rd_out = 0, illegal = 0, in_ready = 1.
- Latency: an input accepted at edge N appears at out_valid/sh_* after edge N (1 cycle) when OR is empty or transferring.
- Throughput: 1 entry/cycle with out_ready held high.
- Stability: while out_valid && !out_ready, every output payload bit is held constant.
- in_ready falls the cycle after SK fills and rises the cycle after SK drains.
- Flush while SK is full: in_ready = 1 the next cycle.
- Reset asserted mid-transfer: all state is lost immediately, regardless of clock.

## Test plan
- SLLI: funct3=001, funct7_5=0, is_imm=1, imm_shamt=4, rs1=0x0000_00F1, out_ready=1 -> next cycle out_valid=1, sh_type=01, sh_shamt=4, sh_a=0x0000_00F1, illegal=0.
- SRA register form: funct3=101, funct7_5=1, rs2=0xFFFF_FFE3 -> sh_shamt=3, sh_type=10.
- Backpressure: out_ready=0, three back-to-back inputs A, B, C:
  - A is held in OR, B goes to SK, in_ready drops and C is held upstream.
  - Raise out_ready -> outputs A, B, C in order with no loss.
- Illegal encoding: funct3=000 -> sh_type=11, illegal=1, sh_a=rs1_data, the entry is still delivered.
- Flush with OR and SK full -> next cycle out_valid=0 and in_ready=1; a new input then arrives 1 cycle after acceptance.
- Async reset asserted mid-stream between edges -> out_valid=0 and sh_type=11 immediately, and in_ready=1.
